// File: rtl/decode_regfile_unit.sv
// decode_regfile_unit: RV32I OP / OP-IMM decoder with a registered decode stage,
// followed by the 32-entry architectural register file. The register file
// reads combinationally on the registered source indices, so operands line up
// with the control fields. Writeback arrives on an independent write port.
module decode_regfile_unit #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [31:0]     fetched_inst,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [4:0]      reg_rd0_addr,
    output logic [4:0]      reg_rd1_addr,
    output logic [4:0]      reg_wr_addr,
    output logic            reg_rd0_en,
    output logic            reg_rd1_en,
    output logic            reg_wr_en,
    output logic            input_a_is_immediate,
    output logic [11:0]     inst_imm,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] rd0_data,
    output logic [XLEN-1:0] rd1_data
);

    typedef enum logic [3:0] {
        ALU_NONE = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10
    } alu_command_t;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // funct3 -> ALU command shared by OP and OP-IMM; alt is inst[30], which
    // only selects SRA over SRL here (SUB is handled by the OP caller).
    function automatic alu_command_t map_funct3(input logic [2:0] f3, input logic alt);
        alu_command_t cmd;
        case (f3)
            3'b000:  cmd = ALU_ADD;
            3'b001:  cmd = ALU_SLL;
            3'b010:  cmd = ALU_SLT;
            3'b011:  cmd = ALU_SLTU;
            3'b100:  cmd = ALU_XOR;
            3'b101:  cmd = alt ? ALU_SRA : ALU_SRL;
            3'b110:  cmd = ALU_OR;
            default: cmd = ALU_AND;
        endcase
        return cmd;
    endfunction

    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    logic         funct7_ok;

    logic [4:0]   nxt_rd0_addr;
    logic [4:0]   nxt_rd1_addr;
    logic [4:0]   nxt_wr_addr;
    logic         nxt_rd0_en;
    logic         nxt_rd1_en;
    logic         nxt_wr_en;
    logic         nxt_a_is_imm;
    logic [11:0]  nxt_imm;
    alu_command_t nxt_op;

    logic [XLEN-1:0] regs [NREGS];

    assign opcode    = fetched_inst[6:0];
    assign funct3    = fetched_inst[14:12];
    assign funct7    = fetched_inst[31:25];
    assign funct7_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);

    // Combinational decode; anything unrecognised falls through to all-zero.
    always_comb begin
        nxt_rd0_addr = '0;
        nxt_rd1_addr = '0;
        nxt_wr_addr  = '0;
        nxt_rd0_en   = 1'b0;
        nxt_rd1_en   = 1'b0;
        nxt_wr_en    = 1'b0;
        nxt_a_is_imm = 1'b0;
        nxt_imm      = '0;
        nxt_op       = ALU_NONE;
        case (opcode)
            OPC_OP_IMM: begin
                nxt_rd1_addr = fetched_inst[19:15];
                nxt_rd1_en   = 1'b1;
                nxt_wr_addr  = fetched_inst[11:7];
                nxt_wr_en    = 1'b1;
                nxt_a_is_imm = 1'b1;
                nxt_imm      = fetched_inst[31:20];
                nxt_op       = map_funct3(funct3, fetched_inst[30]);
            end
            OPC_OP: begin
                if (funct7_ok) begin
                    nxt_rd1_addr = fetched_inst[19:15];
                    nxt_rd0_addr = fetched_inst[24:20];
                    nxt_rd1_en   = 1'b1;
                    nxt_rd0_en   = 1'b1;
                    nxt_wr_addr  = fetched_inst[11:7];
                    nxt_wr_en    = 1'b1;
                    if (funct3 == 3'b000) begin
                        nxt_op = fetched_inst[30] ? ALU_SUB : ALU_ADD;
                    end else begin
                        nxt_op = map_funct3(funct3, fetched_inst[30]);
                    end
                end
            end
            default: ;
        endcase
    end

    // Decode pipeline register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_rd0_addr         <= '0;
            reg_rd1_addr         <= '0;
            reg_wr_addr          <= '0;
            reg_rd0_en           <= 1'b0;
            reg_rd1_en           <= 1'b0;
            reg_wr_en            <= 1'b0;
            input_a_is_immediate <= 1'b0;
            inst_imm             <= '0;
            alu_op               <= ALU_NONE;
        end else begin
            reg_rd0_addr         <= nxt_rd0_addr;
            reg_rd1_addr         <= nxt_rd1_addr;
            reg_wr_addr          <= nxt_wr_addr;
            reg_rd0_en           <= nxt_rd0_en;
            reg_rd1_en           <= nxt_rd1_en;
            reg_wr_en            <= nxt_wr_en;
            input_a_is_immediate <= nxt_a_is_imm;
            inst_imm             <= nxt_imm;
            alu_op               <= nxt_op;
        end
    end

    // Register file write port; x0 is never written so it stays zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != 5'd0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Read ports: no write bypass, so a same-cycle write shows up after the edge.
    assign rd0_data = (reg_rd0_en && (reg_rd0_addr != 5'd0)) ? regs[reg_rd0_addr] : '0;
    assign rd1_data = (reg_rd1_en && (reg_rd1_addr != 5'd0)) ? regs[reg_rd1_addr] : '0;

endmodule

// File: tb/tb_decode_regfile_unit.sv
// Directed bench for decode_regfile_unit.
module tb_decode_regfile_unit;

    logic        clk;
    logic        reset_n;
    logic [31:0] fetched_inst;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  reg_rd0_addr;
    logic [4:0]  reg_rd1_addr;
    logic [4:0]  reg_wr_addr;
    logic        reg_rd0_en;
    logic        reg_rd1_en;
    logic        reg_wr_en;
    logic        input_a_is_immediate;
    logic [11:0] inst_imm;
    logic [3:0]  alu_op;
    logic [31:0] rd0_data;
    logic [31:0] rd1_data;

    int errors = 0;
    int checks = 0;

    decode_regfile_unit #(.XLEN(32), .NREGS(32)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .fetched_inst         (fetched_inst),
        .wb_en                (wb_en),
        .wb_addr              (wb_addr),
        .wb_data              (wb_data),
        .reg_rd0_addr         (reg_rd0_addr),
        .reg_rd1_addr         (reg_rd1_addr),
        .reg_wr_addr          (reg_wr_addr),
        .reg_rd0_en           (reg_rd0_en),
        .reg_rd1_en           (reg_rd1_en),
        .reg_wr_en            (reg_wr_en),
        .input_a_is_immediate (input_a_is_immediate),
        .inst_imm             (inst_imm),
        .alu_op               (alu_op),
        .rd0_data             (rd0_data),
        .rd1_data             (rd1_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd);
        fetched_inst = inst;
        wb_en        = we;
        wb_addr      = wa;
        wb_data      = wd;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(32'h0, 1'b0, 5'd0, 32'h0);
        #2;
        check("rst_alu_op", {28'd0, alu_op}, 32'd0);
        check("rst_wr_en", {31'd0, reg_wr_en}, 32'd0);
        check("rst_rd1_data", rd1_data, 32'd0);
        check("rst_rd0_data", rd0_data, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;

        // Write x3 and decode ADDI x4,x3,5 on the same edge.
        drive(32'h00518213, 1'b1, 5'd3, 32'h0000_1234);
        tick();
        check("addi_alu_op", {28'd0, alu_op}, 32'd1);
        check("addi_a_imm", {31'd0, input_a_is_immediate}, 32'd1);
        check("addi_imm", {20'd0, inst_imm}, 32'h005);
        check("addi_rd1_addr", {27'd0, reg_rd1_addr}, 32'd3);
        check("addi_rd1_data", rd1_data, 32'h0000_1234);
        check("addi_wr_addr", {27'd0, reg_wr_addr}, 32'd4);
        check("addi_wr_en", {31'd0, reg_wr_en}, 32'd1);
        check("addi_rd0_en", {31'd0, reg_rd0_en}, 32'd0);
        check("addi_rd1_en", {31'd0, reg_rd1_en}, 32'd1);
        check("addi_rd0_data", rd0_data, 32'd0);

        // x1=10, x2=3, then SUB x7,x1,x2.
        drive(32'h0, 1'b1, 5'd1, 32'd10);
        tick();
        drive(32'h0, 1'b1, 5'd2, 32'd3);
        tick();
        check("zero_inst_alu_op", {28'd0, alu_op}, 32'd0);
        drive(32'h402083B3, 1'b0, 5'd0, 32'h0);
        tick();
        check("sub_alu_op", {28'd0, alu_op}, 32'd2);
        check("sub_rd1_data", rd1_data, 32'd10);
        check("sub_rd0_data", rd0_data, 32'd3);
        check("sub_rd0_en", {31'd0, reg_rd0_en}, 32'd1);
        check("sub_rd1_en", {31'd0, reg_rd1_en}, 32'd1);
        check("sub_rd0_addr", {27'd0, reg_rd0_addr}, 32'd2);
        check("sub_wr_addr", {27'd0, reg_wr_addr}, 32'd7);
        check("sub_a_imm", {31'd0, input_a_is_immediate}, 32'd0);
        check("sub_imm", {20'd0, inst_imm}, 32'd0);

        // Other R-type / I-type funct3 mappings.
        drive(32'h0020C2B3, 1'b0, 5'd0, 32'h0);
        tick();
        check("xor_alu_op", {28'd0, alu_op}, 32'd5);
        drive(32'h0020A2B3, 1'b0, 5'd0, 32'h0);
        tick();
        check("slt_alu_op", {28'd0, alu_op}, 32'd9);
        drive(32'h0FF17313, 1'b0, 5'd0, 32'h0);
        tick();
        check("andi_alu_op", {28'd0, alu_op}, 32'd3);
        check("andi_imm", {20'd0, inst_imm}, 32'h0FF);
        check("andi_rd1_data", rd1_data, 32'd3);

        // SRAI then SRLI.
        drive(32'h4030D093, 1'b0, 5'd0, 32'h0);
        tick();
        check("srai_alu_op", {28'd0, alu_op}, 32'd8);
        check("srai_imm", {20'd0, inst_imm}, 32'h403);
        check("srai_rd1_data", rd1_data, 32'd10);
        drive(32'h0030D093, 1'b0, 5'd0, 32'h0);
        tick();
        check("srli_alu_op", {28'd0, alu_op}, 32'd7);
        check("srli_imm", {20'd0, inst_imm}, 32'h003);

        // Write to x0 is dropped; ADDI x1,x0,0 reads zero.
        drive(32'h00000093, 1'b1, 5'd0, 32'hFFFF_FFFF);
        tick();
        check("x0_rd1_addr", {27'd0, reg_rd1_addr}, 32'd0);
        check("x0_rd1_data", rd1_data, 32'd0);
        drive(32'h00000093, 1'b0, 5'd0, 32'h0);
        tick();
        check("x0_rd1_data_later", rd1_data, 32'd0);

        // rd=x0 still asserts the write enable.
        drive(32'h00108013, 1'b0, 5'd0, 32'h0);
        tick();
        check("rdx0_wr_en", {31'd0, reg_wr_en}, 32'd1);
        check("rdx0_wr_addr", {27'd0, reg_wr_addr}, 32'd0);
        check("rdx0_rd1_data", rd1_data, 32'd10);

        // Illegal / unsupported encodings.
        drive(32'h00000000, 1'b0, 5'd0, 32'h0);
        tick();
        check("zero_alu_op", {28'd0, alu_op}, 32'd0);
        check("zero_enables", {29'd0, reg_rd0_en, reg_rd1_en, reg_wr_en}, 32'd0);
        drive(32'h004000EF, 1'b0, 5'd0, 32'h0);
        tick();
        check("jal_alu_op", {28'd0, alu_op}, 32'd0);
        check("jal_enables", {29'd0, reg_rd0_en, reg_rd1_en, reg_wr_en}, 32'd0);
        check("jal_wr_addr", {27'd0, reg_wr_addr}, 32'd0);
        check("jal_a_imm", {31'd0, input_a_is_immediate}, 32'd0);
        drive(32'h0000006F, 1'b0, 5'd0, 32'h0);
        tick();
        check("jal0_alu_op", {28'd0, alu_op}, 32'd0);
        drive(32'h022081B3, 1'b0, 5'd0, 32'h0);
        tick();
        check("f7_alu_op", {28'd0, alu_op}, 32'd0);
        check("f7_enables", {29'd0, reg_rd0_en, reg_rd1_en, reg_wr_en}, 32'd0);
        check("f7_addrs", {17'd0, reg_rd0_addr, reg_rd1_addr, reg_wr_addr}, 32'd0);
        check("f7_rd1_data", rd1_data, 32'd0);

        // Read during write of x9: old value until the edge.
        drive(32'h00048513, 1'b0, 5'd0, 32'h0);
        tick();
        check("rdw_before", rd1_data, 32'd0);
        drive(32'h00048513, 1'b1, 5'd9, 32'hA5A5_A5A5);
        #2;
        check("rdw_same_cycle", rd1_data, 32'd0);
        tick();
        check("rdw_after", rd1_data, 32'hA5A5_A5A5);

        // x5=0x55, read it back, then reset mid-cycle.
        drive(32'h00028093, 1'b1, 5'd5, 32'h0000_0055);
        tick();
        check("x5_pre_reset", rd1_data, 32'h0000_0055);
        drive(32'h00028093, 1'b1, 5'd5, 32'h0000_0077);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_alu_op", {28'd0, alu_op}, 32'd0);
        check("mid_rst_rd1_data", rd1_data, 32'd0);
        check("mid_rst_enables", {29'd0, reg_rd0_en, reg_rd1_en, reg_wr_en}, 32'd0);
        check("mid_rst_a_imm", {31'd0, input_a_is_immediate}, 32'd0);
        tick();
        check("rst_hold_alu_op", {28'd0, alu_op}, 32'd0);
        reset_n = 1'b1;
        drive(32'h00028093, 1'b0, 5'd0, 32'h0);
        tick();
        check("post_rst_alu_op", {28'd0, alu_op}, 32'd1);
        check("post_rst_rd1_addr", {27'd0, reg_rd1_addr}, 32'd5);
        check("post_rst_x5", rd1_data, 32'd0);
        drive(32'h00048093, 1'b0, 5'd0, 32'h0);
        tick();
        check("post_rst_x9", rd1_data, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_regfile_unit.md
Name: decode_regfile_unit

Overview:
- Combines the RV32I integer instruction decoder with the 32x32-bit architectural register file, including the regfile interface wiring, in one block.
- Sits between fetch stage 1 (supplies `fetched_inst`) and the ALU stage.
- Each cycle it registers the decoded control fields. The register file answers those decoded read addresses combinationally, so operands are valid in the same cycle as the control fields.
- Writeback enters on a separate write port.

Parameters:
- XLEN, 32, register and data width.
- NREGS, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- fetched_inst  in  32  instruction word from fetch
- wb_en  in  1  writeback enable
- wb_addr  in  5  writeback register index
- wb_data  in  32  writeback value
- reg_rd0_addr  out  5  decoded rs2 index
- reg_rd1_addr  out  5  decoded rs1 index
- reg_wr_addr  out  5  decoded rd index
- reg_rd0_en  out  1  rs2 read valid
- reg_rd1_en  out  1  rs1 read valid
- reg_wr_en  out  1  instruction writes rd
- input_a_is_immediate  out  1  operand A is inst_imm
- inst_imm  out  12  raw I-immediate, inst[31:20]
- alu_op  out  4  alu_command_t
- rd0_data  out  32  register file read port 0 data
- rd1_data  out  32  register file read port 1 data

Behaviour:
- alu_command_t encoding: ALU_NONE=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, SLL=6, SRL=7, SRA=8, SLT=9, SLTU=10. Values 11-15 are unused and never produced.
- Decode timing:
  - All decode outputs are registered on posedge clk from `fetched_inst`.
  - Latency is 1 cycle; a new decode is produced every cycle (no handshake).
- OP-IMM (opcode 0010011):
  - reg_rd1_addr=inst[19:15], reg_rd1_en=1, reg_rd0_en=0.
  - reg_wr_addr=inst[11:7], reg_wr_en=1.
  - input_a_is_immediate=1, inst_imm=inst[31:20].
  - funct3 mapping: 000 ADD, 111 AND, 110 OR, 100 XOR, 010 SLT, 011 SLTU, 001 SLL, 101 SRL if inst[30]=0 else SRA.
- OP (opcode 0110011):
  - reg_rd1_addr=rs1, reg_rd0_addr=inst[24:20]; both read enables=1.
  - reg_wr_en=1, input_a_is_immediate=0, inst_imm=0.
  - funct3 000 gives ADD if inst[30]=0 else SUB. Other funct3 values map as for OP-IMM.
  - funct7 values other than 0000000/0100000 are illegal.
- Any other opcode, or an illegal funct7:
  - alu_op=ALU_NONE.
  - All enables=0, input_a_is_immediate=0.
  - All addresses=0, inst_imm=0.
  - This covers the all-zero instruction.
- rd=x0 still asserts reg_wr_en; the register file ignores the write.
- Read ports:
  - Combinational on the registered addresses: rdN_data = regs[reg_rdN_addr] when reg_rdN_en=1, else 0.
  - Reading x0 returns 0.
- Write port:
  - Synchronous on posedge when wb_en=1 and wb_addr!=0.
  - wb_en with wb_addr=0 has no effect.
- Read during write to the same register returns the old value until the edge; there is no bypass.
- Reset (asynchronous assert, synchronous-clean deassert):
  - All decode outputs go to 0 (alu_op=ALU_NONE).
  - All 32 registers clear to 0, so rd0_data=rd1_data=0.
  - A reset mid-operation discards any in-flight decode and any same-edge write.

Test Plan:
- Reset: assert reset_n=0 mid-run -> all outputs 0 immediately; after release, reading x5 returns 0.
- Writeback: wb x3=0x0000_1234, then decode ADDI x4,x3,5 (0x00518213) -> next cycle alu_op=ADD, input_a_is_immediate=1, inst_imm=0x005, reg_rd1_addr=3, rd1_data=0x1234, reg_wr_addr=4, reg_wr_en=1.
- R-type: decode SUB x7,x1,x2 (0x402083B3) with x1=10, x2=3 -> alu_op=SUB, rd1_data=10, rd0_data=3, both enables=1, reg_wr_addr=7.
- SRAI: decode 0x4030D093 -> alu_op=SRA, inst_imm=0x403. Change to SRLI 0x0030D093 -> alu_op=SRL.
- x0 and illegal: wb x0=0xFFFF_FFFF then read x0 -> 0. fetched_inst=0x00000000 or 0x0000006F -> alu_op=NONE, all enables 0.
- Read-during-write: wb x9=0xA5A5A5A5 while x9 is decoded as a source -> old value in that cycle, new value the following cycle.
